gcd_lcm_seq: RTL and testbench



---
 rtl/gcd_lcm_seq_if.sv | 37 +++
 rtl/gcd_lcm_seq.sv | 151 +++++++++++++++
 tb/tb_gcd_lcm_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_lcm_seq_if.sv
// Handshake bundle between the core's decoder/writeback path and the gcd/lcm sequencer.
// Optional GCDLCM_OVF_SAT_EN adds the ovf flag.
interface gcd_lcm_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_lcm;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef GCDLCM_OVF_SAT_EN
  logic             ovf;

  modport master (
    output start, is_lcm, srca, srcb,
    input  stall, busy, done, result, ovf
  );

  modport slave (
    input  start, is_lcm, srca, srcb,
    output stall, busy, done, result, ovf
  );
`else
  modport master (
    output start, is_lcm, srca, srcb,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, is_lcm, srca, srcb,
    output stall, busy, done, result
  );
`endif
endinterface

// File: rtl/gcd_lcm_seq.sv
// Multicycle gcd/lcm unit: subtractive Euclid, restoring divider and shift-add multiplier
// under one FSM. Define GCDLCM_OVF_SAT_EN to saturate overflowing lcm results and flag ovf.
module gcd_lcm_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  gcd_lcm_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a, b, a0, b0;    // a doubles as g once a==b
  logic               op;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;             // dividend/quotient in DIV, multiplier in MUL
  logic [2*WIDTH-1:0] mcand, acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   result_q;
  logic               ovf_q;

  logic               zero_op;
  logic [WIDTH:0]     trial;
  logic               fits;
  logic [2*WIDTH-1:0] acc_nx;
  logic               last;

  assign zero_op = (bus.srca == '0) || (bus.srcb == '0);
  assign trial   = {rem, quo[WIDTH-1]};
  assign fits    = trial >= {1'b0, a};
  assign acc_nx  = quo[0] ? acc + mcand : acc;
  assign last    = cnt == CW'(WIDTH - 1);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nx  = state;
    bus.stall = 1'b0;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy  = 1'b0;
        bus.stall = bus.start;
        if (bus.start) state_nx = zero_op ? DONE : GCD;
      end
      GCD: begin
        bus.stall = 1'b1;
        if (a == b) state_nx = op ? DIV : DONE;
      end
      DIV: begin
        bus.stall = 1'b1;
        if (last) state_nx = MUL;
      end
      MUL: begin
        bus.stall = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      a0       <= '0;
      b0       <= '0;
      op       <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a     <= bus.srca;
            b     <= bus.srcb;
            a0    <= bus.srca;
            b0    <= bus.srcb;
            op    <= bus.is_lcm;
            ovf_q <= 1'b0;
            // With one operand zero, gcd is the other operand (srca|srcb); lcm is zero.
            if (zero_op) result_q <= bus.is_lcm ? '0 : (bus.srca | bus.srcb);
          end
        end
        GCD: begin
          if (a > b) begin
            a <= a - b;
          end else if (b > a) begin
            b <= b - a;
          end else begin
            if (!op) result_q <= a;
            rem <= '0;
            quo <= a0;
            cnt <= '0;
          end
        end
        DIV: begin
          // rem < g always, so the trial difference fits back into WIDTH bits.
          rem <= fits ? WIDTH'(trial - {1'b0, a}) : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, b0};
          end
        end
        MUL: begin
          acc   <= acc_nx;
          mcand <= mcand << 1;
          quo   <= quo >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
`ifdef GCDLCM_OVF_SAT_EN
            if (acc_nx[2*WIDTH-1:WIDTH] != '0) begin
              result_q <= '1;
              ovf_q    <= 1'b1;
            end else begin
              result_q <= acc_nx[WIDTH-1:0];
            end
`else
            result_q <= acc_nx[WIDTH-1:0];
`endif
          end
        end
        DONE: ovf_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
`ifdef GCDLCM_OVF_SAT_EN
  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_gcd_lcm_seq.sv
// Self-checking bench for gcd_lcm_seq: directed vector table, hand-written reset and
// back-to-back sequences, and randomized operands against an arithmetic reference model.
module tb_gcd_lcm_seq;

  localparam int W     = 32;
  localparam int LIMIT = 400;
`ifdef GCDLCM_OVF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         l;
    logic [W-1:0] r;
    int           c;
    logic         o;
    string        nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  gcd_lcm_seq_if #(.WIDTH(W)) bus ();

  gcd_lcm_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: Euclid by division; subtractive step count equals the sum of quotients.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic l,
                                output logic [W-1:0] r, output int cyc, output logic o);
    logic [W-1:0]  x, y, t, g;
    logic [63:0]   p;
    int            steps;
    o = 1'b0;
    if (a == 0 || b == 0) begin
      r   = l ? '0 : (a | b);
      cyc = 1;
      return;
    end
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    steps = 0;
    forever begin
      steps += int'(x / y);
      t = x % y;
      if (t == 0) break;
      x = y;
      y = t;
    end
    g = y;
    p = 64'(a / g) * 64'(b);
    if (!l) begin
      r = g;
    end else if (SAT && p[63:32] != 0) begin
      r = '1;
      o = 1'b1;
    end else begin
      r = p[31:0];
    end
    cyc = 1 + steps + (l ? 2 * W : 0);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic l,
                        input logic [W-1:0] er, input int ec, input logic eo, input string nm);
    int cyc;
    bit got;
    bit stall_ok;
    bus.start  = 1'b1;
    bus.is_lcm = l;
    bus.srca   = a;
    bus.srcb   = b;
    #1;
    stall_ok = (bus.stall === 1'b1);
    cyc = 0;
    got = 0;
    while (!got && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      bus.start  = 1'b0;
      bus.is_lcm = 1'($urandom);
      bus.srca   = $urandom;
      bus.srcb   = $urandom;
      if (bus.done === 1'b1) got = 1;
      else if (bus.stall !== 1'b1) stall_ok = 0;
    end
    check({nm, " done seen"}, 64'(got), 64'd1);
    check({nm, " latency"}, 64'(cyc), 64'(ec));
    check({nm, " result"}, 64'(bus.result), 64'(er));
    check({nm, " stall in done"}, 64'(bus.stall), 64'd0);
    check({nm, " stall while busy"}, 64'(stall_ok), 64'd1);
`ifdef GCDLCM_OVF_SAT_EN
    check({nm, " ovf"}, 64'(bus.ovf), 64'(eo));
`else
    if (eo !== 1'b0) check({nm, " ovf expectation"}, 64'(eo), 64'd0);
`endif
    @(posedge clk); #1;
    check({nm, " done one-shot"}, 64'(bus.done), 64'd0);
    check({nm, " idle busy"}, 64'(bus.busy), 64'd0);
    check({nm, " result held"}, 64'(bus.result), 64'(er));
`ifdef GCDLCM_OVF_SAT_EN
    check({nm, " ovf cleared"}, 64'(bus.ovf), 64'd0);
`endif
  endtask

  initial begin
    vec_t tbl[$];
    logic [W-1:0] ra, rb, rr;
    logic         rl, ro;
    int           rc, n_done, cyc;
    bit           dn;
    int           d_cyc[2];
    logic [W-1:0] d_res[2];

    tbl.push_back('{32'd12, 32'd18, 1'b0, 32'd6,  4,  1'b0, "gcd(12,18)"});
    tbl.push_back('{32'd4,  32'd6,  1'b1, 32'd12, 68, 1'b0, "lcm(4,6)"});
    tbl.push_back('{32'd0,  32'd7,  1'b0, 32'd7,  1,  1'b0, "gcd(0,7)"});
    tbl.push_back('{32'd7,  32'd0,  1'b0, 32'd7,  1,  1'b0, "gcd(7,0)"});
    tbl.push_back('{32'd0,  32'd0,  1'b0, 32'd0,  1,  1'b0, "gcd(0,0)"});
    tbl.push_back('{32'd9,  32'd0,  1'b1, 32'd0,  1,  1'b0, "lcm(9,0)"});
    tbl.push_back('{32'd0,  32'd0,  1'b1, 32'd0,  1,  1'b0, "lcm(0,0)"});
    tbl.push_back('{32'd8,  32'd8,  1'b0, 32'd8,  2,  1'b0, "gcd(8,8)"});
    tbl.push_back('{32'hC000_0000, 32'h8000_0000, 1'b1,
                    SAT ? 32'hFFFF_FFFF : 32'h8000_0000, 68, SAT, "lcm overflow"});

    bus.start  = 1'b0;
    bus.is_lcm = 1'b0;
    bus.srca   = '0;
    bus.srcb   = '0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
`ifdef GCDLCM_OVF_SAT_EN
    check("reset ovf", 64'(bus.ovf), 64'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].nm);

    // Reset in the middle of the MUL phase of lcm(4,6).
    bus.start = 1'b1; bus.is_lcm = 1'b1; bus.srca = 32'd4; bus.srcb = 32'd6;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) dn = 1;
    end
    check("midreset busy before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    if (bus.done === 1'b1) dn = 1;
    check("midreset stall", 64'(bus.stall), 64'd0);
    check("midreset busy", 64'(bus.busy), 64'd0);
    check("midreset result", 64'(bus.result), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    if (bus.done === 1'b1) dn = 1;
    check("midreset no done", 64'(dn), 64'd0);
    run_op(32'd8, 32'd8, 1'b0, 32'd8, 2, 1'b0, "gcd(8,8) after reset");

    // Back-to-back: start held high through gcd(5,5) and into lcm(3,5).
    bus.start = 1'b1; bus.is_lcm = 1'b0; bus.srca = 32'd5; bus.srcb = 32'd5;
    n_done = 0;
    cyc = 0;
    d_cyc = '{0, 0};
    d_res = '{32'd0, 32'd0};
    while (n_done < 2 && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin bus.is_lcm = 1'b1; bus.srca = 32'd3; bus.srcb = 32'd5; end
      if (cyc == 4) begin bus.is_lcm = 1'b0; bus.srca = $urandom; bus.srcb = $urandom; end
      if (bus.done === 1'b1) begin
        d_cyc[n_done] = cyc;
        d_res[n_done] = bus.result;
        n_done++;
        if (n_done == 2) bus.start = 1'b0;
      end
    end
    check("b2b pulses", 64'(n_done), 64'd2);
    check("b2b first cycle", 64'(d_cyc[0]), 64'd2);
    check("b2b first result", 64'(d_res[0]), 64'd5);
    check("b2b second cycle", 64'(d_cyc[1]), 64'd72);
    check("b2b second result", 64'(d_res[1]), 64'd15);
    @(posedge clk); #1;
    check("b2b idle after", 64'(bus.busy), 64'd0);

    // Randomized operands sharing a common factor to keep Euclid short.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] g;
      g  = W'($urandom_range(134217727, 1));
      ra = g * W'($urandom_range(31, 1));
      rb = g * W'($urandom_range(31, 1));
      if ($urandom_range(7, 0) == 0) ra = '0;
      if ($urandom_range(7, 0) == 0) rb = '0;
      rl = 1'($urandom);
      model(ra, rb, rl, rr, rc, ro);
      run_op(ra, rb, rl, rr, rc, ro, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
